// File: rtl/tick_rate_divider_if.sv
// Bundle between the tick rate divider and its requester.
// Carries the count enable, the divisor load/ack handshake and the divided outputs.
interface tick_rate_divider_if #(
  parameter int WIDTH = 8
);
  logic             tick_in;
  logic             enable;
  logic [WIDTH-1:0] div_value;
  logic             div_load;
  logic             div_ack;
  logic             div_err;
  logic [WIDTH-1:0] count;
  logic             tick_out;
  logic             wave_out;
  logic             pend;

  modport master (
    output tick_in, enable, div_value, div_load,
    input  div_ack, div_err, count, tick_out, wave_out, pend
  );

  modport slave (
    input  tick_in, enable, div_value, div_load,
    output div_ack, div_err, count, tick_out, wave_out, pend
  );
endinterface

// File: rtl/tick_rate_divider.sv
// Programmable divider of the upstream terminal pulse: registered tick and square wave,
// with divisor changes deferred to a period boundary so no short period is ever emitted.
module tick_rate_divider #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 10
) (
  input  logic               clk,
  input  logic               reset,
  tick_rate_divider_if.slave bus
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] active_div_r;
  logic [WIDTH-1:0] pending_div_r;
  logic             pend_r;
  logic             tick_out_r;
  logic             wave_r;
  logic             ack_r;
  logic             err_r;

  logic [WIDTH-1:0] last_s;
  logic [WIDTH-1:0] count_nxt_s;
  logic [WIDTH-1:0] active_nxt_s;
  logic [WIDTH:0]   half_s;
  logic             wrap_s;
  logic             apply_s;
  logic             capture_s;
  logic             reject_s;
  logic             pend_nxt_s;
  logic             wave_nxt_s;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: the mode for the coming edge follows enable directly
  always_comb begin
    state_nxt_s = S_IDLE;
    if (bus.enable) begin
      state_nxt_s = S_RUN;
    end else begin
      state_nxt_s = S_IDLE;
    end
  end

  // Datapath decode for the coming edge
  always_comb begin
    last_s      = active_div_r - ONE;
    count_nxt_s = ZERO;
    wrap_s      = 1'b0;
    apply_s     = 1'b0;
    capture_s   = 1'b0;
    reject_s    = 1'b0;

    if (bus.div_load && !pend_r) begin
      if (bus.div_value != ZERO) begin
        capture_s = 1'b1;
      end else begin
        reject_s = 1'b1;
      end
    end else begin
      capture_s = 1'b0;
      reject_s  = 1'b0;
    end

    case (state_nxt_s)
      S_RUN: begin
        if (bus.tick_in) begin
          if (count_r == last_s) begin
            wrap_s      = 1'b1;
            count_nxt_s = ZERO;
          end else begin
            count_nxt_s = count_r + ONE;
          end
        end else begin
          count_nxt_s = count_r;
        end
        apply_s = pend_r && wrap_s;
      end
      S_IDLE: begin
        count_nxt_s = ZERO;
        apply_s     = pend_r;
      end
      default: begin
        count_nxt_s = ZERO;
        apply_s     = 1'b0;
      end
    endcase

    // apply needs pend_r=1 and capture needs pend_r=0, so they never collide
    if (apply_s) begin
      active_nxt_s = pending_div_r;
      pend_nxt_s   = 1'b0;
    end else if (capture_s) begin
      active_nxt_s = active_div_r;
      pend_nxt_s   = 1'b1;
    end else begin
      active_nxt_s = active_div_r;
      pend_nxt_s   = pend_r;
    end

    half_s = ({1'b0, active_nxt_s} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    if (state_nxt_s == S_RUN) begin
      wave_nxt_s = ({1'b0, count_nxt_s} < half_s);
    end else begin
      wave_nxt_s = 1'b0;
    end
  end

  // Counter, divisor and handshake registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r       <= ZERO;
      active_div_r  <= DEF_DIV;
      pending_div_r <= ZERO;
      pend_r        <= 1'b0;
      tick_out_r    <= 1'b0;
      wave_r        <= 1'b0;
      ack_r         <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      count_r      <= count_nxt_s;
      active_div_r <= active_nxt_s;
      pend_r       <= pend_nxt_s;
      tick_out_r   <= wrap_s;
      wave_r       <= wave_nxt_s;
      ack_r        <= apply_s;
      err_r        <= reject_s;
      if (capture_s) begin
        pending_div_r <= bus.div_value;
      end else begin
        pending_div_r <= pending_div_r;
      end
    end
  end

  assign bus.count    = count_r;
  assign bus.tick_out = tick_out_r;
  assign bus.wave_out = wave_r;
  assign bus.pend     = pend_r;
  assign bus.div_ack  = ack_r;
  assign bus.div_err  = err_r;

  tick_rate_divider_chk #(
    .WIDTH(WIDTH)
  ) u_chk (
    .clk        (clk),
    .reset      (reset),
    .run        (state_r == S_RUN),
    .count      (count_r),
    .active_div (active_div_r),
    .tick_out   (tick_out_r),
    .wave_out   (wave_r),
    .div_ack    (ack_r),
    .div_err    (err_r)
  );

endmodule

// Invariants of the divider state that must hold on every edge.
module tick_rate_divider_chk #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             reset,
  input logic             run,
  input logic [WIDTH-1:0] count,
  input logic [WIDTH-1:0] active_div,
  input logic             tick_out,
  input logic             wave_out,
  input logic             div_ack,
  input logic             div_err
);

  a_ack_err_excl: assert property (@(posedge clk) disable iff (!reset)
    !(div_ack && div_err));

  a_div_nonzero: assert property (@(posedge clk) disable iff (!reset)
    active_div != {WIDTH{1'b0}});

  a_count_range: assert property (@(posedge clk) disable iff (!reset)
    count < active_div);

  a_tick_at_zero: assert property (@(posedge clk) disable iff (!reset)
    tick_out |-> (count == {WIDTH{1'b0}}));

  a_idle_quiet: assert property (@(posedge clk) disable iff (!reset)
    !run |-> ((count == {WIDTH{1'b0}}) && !tick_out && !wave_out));

endmodule

// File: tb/tb_tick_rate_divider.sv
// Directed bench for tick_rate_divider: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_tick_rate_divider;

  localparam int WIDTH = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   pulses;

  tick_rate_divider_if #(.WIDTH(WIDTH)) bus ();

  tick_rate_divider #(
    .WIDTH      (WIDTH),
    .DEFAULT_DIV(10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tk();
    bus.tick_in = 1'b1;
    cyc(1);
    bus.tick_in = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_count"}, 32'(bus.count), 32'd0);
    chk({tag, "_tick"},  32'(bus.tick_out), 32'd0);
    chk({tag, "_wave"},  32'(bus.wave_out), 32'd0);
    chk({tag, "_pend"},  32'(bus.pend), 32'd0);
    chk({tag, "_ack"},   32'(bus.div_ack), 32'd0);
    chk({tag, "_err"},   32'(bus.div_err), 32'd0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    pulses       = 0;
    reset        = 1'b1;
    bus.tick_in  = 1'b0;
    bus.enable   = 1'b0;
    bus.div_value = 8'd0;
    bus.div_load = 1'b0;

    // Reset state
    #1 reset = 1'b0;
    #1 chk_all_zero("reset");
    cyc(2);
    reset = 1'b1;
    bus.enable = 1'b1;
    cyc(1);
    chk("run_start_count", 32'(bus.count), 32'd0);
    chk("run_start_wave", 32'(bus.wave_out), 32'd1);

    // Default divisor 10, tick_in every third clock for 30 ticks
    for (int i = 1; i <= 30; i++) begin
      tk();
      chk("div10_count", 32'(bus.count), 32'(i % 10));
      chk("div10_tick", 32'(bus.tick_out), (i % 10 == 0) ? 32'd1 : 32'd0);
      chk("div10_wave", 32'(bus.wave_out), (i % 10 < 5) ? 32'd1 : 32'd0);
      if (bus.tick_out === 1'b1) pulses++;
      cyc(1);
      chk("div10_tick_gap", 32'(bus.tick_out), 32'd0);
      cyc(1);
    end
    chk("div10_pulses", 32'(pulses), 32'd3);

    // Load 5 at count 3; applied at the wrap of the current 10-period
    for (int i = 1; i <= 3; i++) tk();
    chk("load5_count", 32'(bus.count), 32'd3);
    bus.div_value = 8'd5;
    bus.div_load  = 1'b1;
    cyc(1);
    chk("load5_pend", 32'(bus.pend), 32'd1);
    for (int c = 4; c <= 9; c++) begin
      tk();
      chk("load5_pend_hold", 32'(bus.pend), 32'd1);
      chk("load5_no_ack", 32'(bus.div_ack), 32'd0);
      chk("load5_old_count", 32'(bus.count), 32'(c));
    end
    tk();
    chk("load5_wrap_tick", 32'(bus.tick_out), 32'd1);
    chk("load5_wrap_count", 32'(bus.count), 32'd0);
    chk("load5_ack", 32'(bus.div_ack), 32'd1);
    chk("load5_pend_clr", 32'(bus.pend), 32'd0);
    bus.div_load = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tk();
      chk("div5_count", 32'(bus.count), 32'(k % 5));
      chk("div5_tick", 32'(bus.tick_out), (k == 5) ? 32'd1 : 32'd0);
      chk("div5_wave", 32'(bus.wave_out), (k % 5 < 3) ? 32'd1 : 32'd0);
      chk("div5_ack_once", 32'(bus.div_ack), 32'd0);
    end

    // Zero divisor is rejected
    bus.div_value = 8'd0;
    bus.div_load  = 1'b1;
    cyc(1);
    chk("zero_err", 32'(bus.div_err), 32'd1);
    chk("zero_pend", 32'(bus.pend), 32'd0);
    bus.div_load = 1'b0;
    cyc(1);
    chk("zero_err_pulse", 32'(bus.div_err), 32'd0);
    chk("zero_pend_after", 32'(bus.pend), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tk();
      chk("zero_keep5_tick", 32'(bus.tick_out), (k == 5) ? 32'd1 : 32'd0);
      chk("zero_keep5_count", 32'(bus.count), 32'(k % 5));
    end

    // Divisor 1 applied while idle, then tick_in every clock
    bus.enable    = 1'b0;
    bus.div_value = 8'd1;
    bus.div_load  = 1'b1;
    cyc(1);
    chk("idle_capture_pend", 32'(bus.pend), 32'd1);
    chk("idle_wave", 32'(bus.wave_out), 32'd0);
    cyc(1);
    chk("idle_apply_ack", 32'(bus.div_ack), 32'd1);
    chk("idle_apply_pend", 32'(bus.pend), 32'd0);
    bus.div_load = 1'b0;
    cyc(1);
    chk("idle_ack_pulse", 32'(bus.div_ack), 32'd0);
    bus.enable  = 1'b1;
    bus.tick_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      chk("div1_tick", 32'(bus.tick_out), 32'd1);
      chk("div1_count", 32'(bus.count), 32'd0);
      chk("div1_wave", 32'(bus.wave_out), 32'd1);
    end
    bus.tick_in = 1'b0;
    cyc(1);
    chk("div1_tick_stop", 32'(bus.tick_out), 32'd0);
    chk("div1_wave_hold", 32'(bus.wave_out), 32'd1);

    // Back to 10, then drop enable at count 7
    bus.enable    = 1'b0;
    bus.div_value = 8'd10;
    bus.div_load  = 1'b1;
    cyc(2);
    chk("reload10_ack", 32'(bus.div_ack), 32'd1);
    bus.div_load = 1'b0;
    bus.enable   = 1'b1;
    cyc(1);
    for (int k = 1; k <= 7; k++) tk();
    chk("en_count7", 32'(bus.count), 32'd7);
    bus.enable = 1'b0;
    cyc(1);
    chk("dis_count", 32'(bus.count), 32'd0);
    chk("dis_tick", 32'(bus.tick_out), 32'd0);
    chk("dis_wave", 32'(bus.wave_out), 32'd0);
    bus.enable = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tk();
      chk("reen_tick", 32'(bus.tick_out), (k == 10) ? 32'd1 : 32'd0);
      chk("reen_count", 32'(bus.count), 32'(k % 10));
    end

    // Asynchronous reset between edges with pend=1 and count=4
    for (int k = 1; k <= 4; k++) tk();
    bus.div_value = 8'd3;
    bus.div_load  = 1'b1;
    cyc(1);
    chk("rst_pre_pend", 32'(bus.pend), 32'd1);
    chk("rst_pre_count", 32'(bus.count), 32'd4);
    #2 reset = 1'b0;
    #1 chk_all_zero("async_rst");
    bus.div_load = 1'b0;
    cyc(1);
    reset = 1'b1;
    cyc(1);
    for (int k = 1; k <= 10; k++) begin
      tk();
      chk("post_rst_tick", 32'(bus.tick_out), (k == 10) ? 32'd1 : 32'd0);
      chk("post_rst_count", 32'(bus.count), 32'(k % 10));
      chk("post_rst_no_ack", 32'(bus.div_ack), 32'd0);
      chk("post_rst_pend", 32'(bus.pend), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
